// File: rtl/pad_pkg.sv
// Shared types and constants for the row sequencer and the column-padding engine.
package pad_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        ROW   = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam int unsigned TUSER_SOF = 0;
    localparam int unsigned TUSER_EOL = 1;
    localparam int unsigned TUSER_EOF = 2;

    // Narrowest row the padding engine can handle.
    localparam int unsigned PAD_MIN_W = 3;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry forward register slice: registered valid/data, ready passes through.
module axis_reg_slice #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready_c,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;

    assign s_ready_c = ~valid_q | m_ready;
    assign m_valid   = valid_q;
    assign m_data    = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (s_valid && s_ready_c) begin
            valid_d = 1'b1;
            data_d  = s_data;
        end else if (m_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pad_row_sequencer.sv
// Cuts an unframed pixel stream into rows for the padding engine, limits rows in
// flight, and counts returned rows to signal frame completion.
module pad_row_sequencer
    import pad_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH  = 8,
    parameter int unsigned TUSER_WIDTH  = 5,
    parameter int unsigned TDEST_WIDTH  = 2,
    parameter int unsigned DIM_WIDTH    = 12,
    parameter int unsigned MAX_INFLIGHT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_start,
    input  logic [DIM_WIDTH-1:0]   cfg_width,
    input  logic [DIM_WIDTH-1:0]   cfg_height,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TDEST_WIDTH-1:0] m_axis_tdest,
    output logic                   m_axis_tlast,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    input  logic                   ret_valid,
    input  logic                   ret_ready,
    input  logic                   ret_last,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   cfg_err
);

    localparam int unsigned          PAY_W   = TDATA_WIDTH + TDEST_WIDTH + 1 + TUSER_WIDTH;
    localparam logic [DIM_WIDTH-1:0] ONE     = DIM_WIDTH'(1);
    localparam logic [DIM_WIDTH-1:0] MAX_OUT = DIM_WIDTH'(MAX_INFLIGHT);

    state_e               state_q, state_d;
    logic [DIM_WIDTH-1:0] w_q, w_d, h_q, h_d;
    logic [DIM_WIDTH-1:0] col_q, col_d, row_q, row_d;
    logic [DIM_WIDTH-1:0] outst_q, outst_d, returned_q, returned_d;
    logic                 busy_q, busy_d, frame_done_q, frame_done_d, cfg_err_q, cfg_err_d;

    logic                   in_row, slice_ready, s_fire, last_pix, issue, ret_ok;
    logic [TUSER_WIDTH-1:0] pix_user;
    logic [PAY_W-1:0]       m_pay;

    assign in_row        = (state_q == ROW);
    assign s_axis_tready = in_row & slice_ready;
    assign s_fire        = s_axis_tvalid & s_axis_tready;
    assign last_pix      = (col_q == w_q - ONE);
    assign issue         = s_fire & last_pix;
    // Returns with nothing outstanding are dropped so the count never underflows.
    assign ret_ok        = ret_valid & ret_ready & ret_last & (outst_q != '0)
                         & (state_q inside {ROW, WAIT, DRAIN});

    always_comb begin
        pix_user            = '0;
        pix_user[TUSER_SOF] = (row_q == '0) && (col_q == '0);
        pix_user[TUSER_EOL] = last_pix;
        pix_user[TUSER_EOF] = last_pix && (row_q == h_q - ONE);
    end

    axis_reg_slice #(.DATA_W(PAY_W)) u_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_axis_tvalid & in_row),
        .s_ready_c (slice_ready),
        .s_data    ({s_axis_tdata, s_axis_tdest, last_pix, pix_user}),
        .m_valid   (m_axis_tvalid),
        .m_ready   (m_axis_tready),
        .m_data    (m_pay)
    );

    assign {m_axis_tdata, m_axis_tdest, m_axis_tlast, m_axis_tuser} = m_pay;

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        col_d      = col_q;
        row_d      = row_q;
        outst_d    = outst_q;
        returned_d = returned_q;
        cfg_err_d  = 1'b0;

        // A simultaneous issue and return cancel out.
        case ({issue, ret_ok})
            2'b10:   outst_d = outst_q + ONE;
            2'b01:   outst_d = outst_q - ONE;
            default: outst_d = outst_q;
        endcase
        if (ret_ok) returned_d = returned_q + ONE;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_width < DIM_WIDTH'(PAD_MIN_W) || cfg_height == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        w_d     = cfg_width;
                        h_d     = cfg_height;
                        state_d = ARM;
                    end
                end
            end
            ARM: begin
                col_d      = '0;
                row_d      = '0;
                outst_d    = '0;
                returned_d = '0;
                state_d    = ROW;
            end
            ROW: begin
                if (s_fire) begin
                    if (last_pix) begin
                        col_d = '0;
                        row_d = row_q + ONE;
                        if (row_q == h_q - ONE)   state_d = DRAIN;
                        else if (outst_d == MAX_OUT) state_d = WAIT;
                    end else begin
                        col_d = col_q + ONE;
                    end
                end
            end
            WAIT:    if (outst_d < MAX_OUT) state_d = ROW;
            DRAIN:   if (returned_d == h_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d       = (state_d inside {ARM, ROW, WAIT, DRAIN});
        frame_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            w_q          <= '0;
            h_q          <= '0;
            col_q        <= '0;
            row_q        <= '0;
            outst_q      <= '0;
            returned_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            h_q          <= h_d;
            col_q        <= col_d;
            row_q        <= row_d;
            outst_q      <= outst_d;
            returned_q   <= returned_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_pad_row_sequencer.sv
// Scoreboard bench for pad_row_sequencer: instance 0 with one row in flight, instance 1 with two.
module tb_pad_row_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned UW = 5;
    localparam int unsigned TW = 2;
    localparam int unsigned NW = 12;
    localparam int unsigned PW = DW + TW + 1 + UW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         rst_n, cfg_start, s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
    logic [1:0]         ret_valid, ret_ready, ret_last, busy, frame_done, cfg_err;
    logic [1:0][NW-1:0] cfg_width, cfg_height;
    logic [1:0][DW-1:0] s_tdata, m_tdata;
    logic [1:0][TW-1:0] s_tdest, m_tdest;
    logic [1:0][UW-1:0] m_tuser;

    pad_row_sequencer #(.MAX_INFLIGHT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .cfg_start(cfg_start[0]),
        .cfg_width(cfg_width[0]), .cfg_height(cfg_height[0]),
        .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
        .s_axis_tdata(s_tdata[0]), .s_axis_tdest(s_tdest[0]),
        .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tdest(m_tdest[0]),
        .m_axis_tlast(m_tlast[0]), .m_axis_tuser(m_tuser[0]),
        .ret_valid(ret_valid[0]), .ret_ready(ret_ready[0]), .ret_last(ret_last[0]),
        .busy(busy[0]), .frame_done(frame_done[0]), .cfg_err(cfg_err[0])
    );

    pad_row_sequencer #(.MAX_INFLIGHT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .cfg_start(cfg_start[1]),
        .cfg_width(cfg_width[1]), .cfg_height(cfg_height[1]),
        .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
        .s_axis_tdata(s_tdata[1]), .s_axis_tdest(s_tdest[1]),
        .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tdest(m_tdest[1]),
        .m_axis_tlast(m_tlast[1]), .m_axis_tuser(m_tuser[1]),
        .ret_valid(ret_valid[1]), .ret_ready(ret_ready[1]), .ret_last(ret_last[1]),
        .busy(busy[1]), .frame_done(frame_done[1]), .cfg_err(cfg_err[1])
    );

    int n_vec = 0;
    int n_err = 0;

    int d = 0;
    int W, H, maxi, dly;
    int cyc, acc_cnt, beats, iss_rows, ret_rows, fd_cnt, fd_at;
    int acc_at [64];
    int ret_at [8];
    logic mon_en = 1'b0;
    logic tog_en = 1'b0;
    logic hold;
    logic [PW-1:0] held;
    logic [PW-1:0] sb_q [$];
    int rq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] mpay(input int i);
        return {m_tdata[i], m_tdest[i], m_tlast[i], m_tuser[i]};
    endfunction

    task automatic new_frame(input int dut, input int w, input int h, input int mx, input int dl);
        d = dut; W = w; H = h; maxi = mx; dly = dl;
        acc_cnt = 0; beats = 0; iss_rows = 0; ret_rows = 0; fd_cnt = 0; fd_at = -1;
        hold = 1'b0;
        sb_q.delete();
        rq.delete();
    endtask

    task automatic start(input int w, input int h);
        cfg_width[d] = NW'(w); cfg_height[d] = NW'(h); cfg_start[d] = 1'b1;
        @(posedge clk); #1;
        cfg_start[d] = 1'b0;
    endtask

    task automatic send(input int n);
        int g;
        for (int k = 0; k < n; k++) begin
            g = 0;
            s_tvalid[d] = 1'b1;
            s_tdata[d]  = DW'($urandom);
            s_tdest[d]  = TW'($urandom);
            @(negedge clk);
            while (!s_tready[d] && g < 2000) begin
                @(negedge clk);
                g++;
            end
            if (g >= 2000) begin
                chk("s_ready_timeout", 32'(g), 32'(0));
                break;
            end
            @(posedge clk); #1;
        end
        s_tvalid[d] = 1'b0;
    endtask

    task automatic wait_done(input int n0);
        int g;
        g = 0;
        while (fd_cnt == n0 && g < 1000) begin
            @(posedge clk); #1;
            g++;
        end
        chk("done_timeout", 32'(fd_cnt > n0), 32'(1));
    endtask

    // Engine stand-in: returns each issued row dly cycles after its tlast beat.
    initial begin
        cyc = 0;
        m_tready = 2'b11; ret_ready = 2'b11; ret_valid = 2'b00; ret_last = 2'b00;
        forever begin
            @(posedge clk);
            cyc++;
            if (ret_valid[d] && ret_ready[d] && rq.size() != 0) begin
                void'(rq.pop_front());
                if (ret_rows < 8) ret_at[ret_rows] = cyc;
                ret_rows++;
            end
            #1;
            ret_valid[d] = (rq.size() != 0) && (rq[0] <= cyc);
            ret_last[d]  = ret_valid[d];
            m_tready[d]  = tog_en ? ~m_tready[d] : 1'b1;
        end
    end

    // Monitor: pushes expected beats on s handshakes, pops and compares on m handshakes.
    initial begin
        int col, row;
        logic sof, eol, eof;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (hold) chk("stall_stable", 32'({m_tvalid[d], mpay(d)}), 32'({1'b1, held}));
                hold = m_tvalid[d] && !m_tready[d];
                held = mpay(d);
                if (m_tvalid[d] && m_tready[d]) begin
                    beats++;
                    if (sb_q.size() == 0) chk("extra_beat", 32'(beats), 32'(0));
                    else chk("beat", 32'(mpay(d)), 32'(sb_q.pop_front()));
                    if (m_tlast[d]) rq.push_back(cyc + dly);
                end
                if (s_tvalid[d] && s_tready[d]) begin
                    col = acc_cnt % W;
                    row = acc_cnt / W;
                    sof = (acc_cnt == 0);
                    eol = (col == W - 1);
                    eof = eol && (row == H - 1);
                    sb_q.push_back({s_tdata[d], s_tdest[d], eol, 2'b00, eof, eol, sof});
                    if (acc_cnt < 64) acc_at[acc_cnt] = cyc + 1;
                    if (eol) begin
                        chk("inflight", 32'((iss_rows + 1 - ret_rows) <= maxi), 32'(1));
                        iss_rows++;
                    end
                    acc_cnt++;
                end
                if (frame_done[d]) begin
                    fd_cnt++;
                    fd_at = cyc;
                    chk("busy_at_done", 32'(busy[d]), 32'(0));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 2'b00; cfg_start = 2'b00; s_tvalid = 2'b00;
        cfg_width = '0; cfg_height = '0; s_tdata = '0; s_tdest = '0;
        new_frame(0, 4, 2, 1, 6);
        #12;
        for (int i = 0; i < 2; i++)
            chk("reset_outputs", 32'({m_tvalid[i], s_tready[i], busy[i], frame_done[i], cfg_err[i],
                                      m_tlast[i], m_tuser[i], m_tdata[i], m_tdest[i]}), 32'(0));
        rst_n = 2'b11;
        @(posedge clk); #1;

        // W=4 H=2, one row in flight, 6-cycle return
        new_frame(0, 4, 2, 1, 6);
        mon_en = 1'b1;
        start(4, 2);
        send(8);
        wait_done(0);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_beats", 32'(beats), 32'(8));
        chk("t1_wait_for_return", 32'(acc_at[4]), 32'(ret_at[0] + 1));
        chk("t1_done_timing", 32'(fd_at), 32'(ret_at[1]));
        chk("t1_done_pulses", 32'(fd_cnt), 32'(1));
        chk("t1_busy_idle", 32'(busy[0]), 32'(0));

        // rejected configurations
        start(2, 5);
        chk("t2_err_pulse", 32'({cfg_err[0], busy[0], s_tready[0]}), 32'(3'b100));
        @(posedge clk); #1;
        chk("t2_err_clear", 32'({cfg_err[0], busy[0], s_tready[0]}), 32'(3'b000));
        start(5, 0);
        chk("t2_h0_err", 32'({cfg_err[0], busy[0]}), 32'(2'b10));
        @(posedge clk); #1;

        // W=5 H=3, two in flight, output ready toggling
        new_frame(1, 5, 3, 2, 12);
        tog_en = 1'b1;
        start(5, 3);
        send(15);
        wait_done(0);
        tog_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_beats", 32'(beats), 32'(15));
        chk("t3_done_pulses", 32'(fd_cnt), 32'(1));

        // W=3: row 0 return coincides with row 1 issue
        new_frame(1, 3, 3, 2, 2);
        start(3, 3);
        send(9);
        wait_done(0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_same_cycle", 32'(ret_at[0]), 32'(acc_at[5]));
        chk("t4_no_stall", 32'(acc_at[6] - acc_at[5]), 32'(1));
        chk("t4_beats", 32'(beats), 32'(9));

        // reset in the middle of the second row
        new_frame(0, 8, 4, 1, 3);
        start(8, 4);
        send(11);
        chk("t5_live", 32'({busy[0], m_tvalid[0]}), 32'(2'b11));
        #3;
        mon_en = 1'b0;
        rst_n[0] = 1'b0;
        #1;
        chk("t5_async_reset", 32'({m_tvalid[0], s_tready[0], busy[0], frame_done[0], cfg_err[0],
                                   m_tlast[0], m_tuser[0], m_tdata[0], m_tdest[0]}), 32'(0));
        @(negedge clk);
        rst_n[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("t5_no_done", 32'({frame_done[0], busy[0]}), 32'(0));
        end
        new_frame(0, 3, 2, 1, 4);
        mon_en = 1'b1;
        start(3, 2);
        send(6);
        wait_done(0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_new_frame_beats", 32'(beats), 32'(6));
        chk("t5_new_frame_done", 32'(fd_cnt), 32'(1));

        // cfg_start during ROW must not change W or H
        new_frame(1, 4, 2, 2, 5);
        start(4, 2);
        send(2);
        start(6, 5);
        send(6);
        wait_done(0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_beats", 32'(beats), 32'(8));
        chk("t6_done_pulses", 32'(fd_cnt), 32'(1));
        chk("t6_idle", 32'(busy[1]), 32'(0));

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
